morse_keyer: RTL and testbench

//   Converts a stream of 2-bit Morse symbol codes into an on/off serial key

---
 rtl/morse_keyer.sv | 175 +++++++++++++++++
 tb/tb_morse_keyer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// ---------------------------------------------------------------------------
// morse_keyer
//   Turns a stream of 2-bit Morse symbol codes into an on/off key line with
//   standard Morse timing. Codes: 01 dot, 10 dash, 11 character space,
//   00 word space. Symbols arrive over a valid/ready handshake. A new symbol
//   can be accepted in the last cycle of the previous symbol's space period,
//   so continuous streams run without idle bubbles.
//
// Parameters
//   UNIT_CYCLES     clk cycles per Morse time unit (>= 1)
//   WORD_GAP_UNITS  low units emitted for code 00 (>= 1)
//
// Ports
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  synchronous active-high reset
//   sym_code    in   2  symbol code, sampled only when a transfer happens
//   sym_valid   in   1  sym_code valid, held by the producer until accepted
//   sym_ready   out  1  keyer can accept (decode of registers only)
//   serial_out  out  1  key line, 1 = mark, 0 = space (registered)
//   busy        out  1  a symbol is being emitted
// ---------------------------------------------------------------------------
module morse_keyer #(
    parameter int UNIT_CYCLES    = 1,
    parameter int WORD_GAP_UNITS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sym_code,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int MAX_UNITS = (WORD_GAP_UNITS > 3) ? WORD_GAP_UNITS : 3;
    localparam int PRESC_W   = $clog2(UNIT_CYCLES + 1);
    localparam int UNIT_W    = $clog2(MAX_UNITS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;   // cycle within the current unit
    logic [UNIT_W-1:0]   units_q, units_d;   // units remaining in the period, minus one
    logic [1:0]          code_q, code_d;     // symbol being emitted
    logic                serial_out_q, serial_out_d;

    logic unit_end;
    logic period_end;
    logic accept;

    // Mark length in units for a symbol code (0 = no mark phase).
    function automatic logic [UNIT_W-1:0] mark_units(input logic [1:0] code);
        case (code)
            2'b01:   return UNIT_W'(1);
            2'b10:   return UNIT_W'(3);
            default: return '0;
        endcase
    endfunction

    // Trailing space length in units for a symbol code.
    function automatic logic [UNIT_W-1:0] space_units(input logic [1:0] code);
        case (code)
            2'b01,
            2'b10:   return UNIT_W'(1);
            2'b11:   return UNIT_W'(2);
            default: return UNIT_W'(WORD_GAP_UNITS);
        endcase
    endfunction

    assign unit_end   = (presc_q == PRESC_LAST);
    assign period_end = unit_end && (units_q == '0);
    assign accept     = sym_valid && sym_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            units_q      <= '0;
            code_q       <= '0;
            serial_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            units_q      <= units_d;
            code_q       <= code_d;
            serial_out_q <= serial_out_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        units_d = units_q;
        code_d  = code_q;

        // Load a freshly accepted symbol: skip MARK for pure space codes.
        if (accept) begin
            code_d  = sym_code;
            presc_d = '0;
            if (mark_units(sym_code) != '0) begin
                state_d = MARK;
                units_d = mark_units(sym_code) - UNIT_W'(1);
            end else begin
                state_d = SPACE;
                units_d = space_units(sym_code) - UNIT_W'(1);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Hold; only an accept leaves IDLE.
                end
                MARK: begin
                    if (period_end) begin
                        state_d = SPACE;
                        presc_d = '0;
                        units_d = space_units(code_q) - UNIT_W'(1);
                    end else if (unit_end) begin
                        presc_d = '0;
                        units_d = units_q - UNIT_W'(1);
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                SPACE: begin
                    if (period_end) begin
                        state_d = IDLE;
                        presc_d = '0;
                        units_d = '0;
                    end else if (unit_end) begin
                        presc_d = '0;
                        units_d = units_q - UNIT_W'(1);
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                    units_d = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // Ready in IDLE, or in the final SPACE cycle so a following symbol
        // starts on the very next cycle.
        sym_ready    = (state_q == IDLE) || ((state_q == SPACE) && period_end);
        busy         = (state_q != IDLE);
        // The key line is registered: it shows the state being entered.
        serial_out_d = (state_d == MARK);
    end

    assign serial_out = serial_out_q;

endmodule

// File: tb/tb_morse_keyer.sv
// ---------------------------------------------------------------------------
// tb_morse_keyer
//   Two keyers run side by side: dut0 with UNIT_CYCLES=1 and dut1 with
//   UNIT_CYCLES=4. A reference model per instance expands each accepted
//   symbol into its full key-line waveform (a queue of future bits); one
//   compare process checks serial_out, busy and sym_ready against it on
//   every falling edge. Directed scenarios add literal expectations taken
//   straight from the Morse timing rules.
// ---------------------------------------------------------------------------
module tb_morse_keyer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] code0, code1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       serial0, serial1;
    logic       busy0, busy1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    logic hist_s0 [0:4095];
    logic hist_s1 [0:4095];
    logic hist_r1 [0:4095];

    always #5 clk = ~clk;

    morse_keyer #(.UNIT_CYCLES(1), .WORD_GAP_UNITS(6)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .sym_code   (code0),
        .sym_valid  (valid0),
        .sym_ready  (ready0),
        .serial_out (serial0),
        .busy       (busy0)
    );

    morse_keyer #(.UNIT_CYCLES(4), .WORD_GAP_UNITS(6)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .sym_code   (code1),
        .sym_valid  (valid1),
        .sym_ready  (ready1),
        .serial_out (serial1),
        .busy       (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: each accepted symbol becomes M*U ones then S*U zeros.
    // The key line emits one queued bit per cycle; ready means nothing left.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int U = (g == 0) ? 1 : 4;
        bit   line_q [$];
        logic exp_serial = 1'b0;
        logic exp_busy   = 1'b0;
        logic exp_ready  = 1'b1;

        always @(posedge clk) begin
            int         m;
            int         s;
            logic [1:0] c;
            logic       v;
            c = (g == 0) ? code0 : code1;
            v = (g == 0) ? valid0 : valid1;
            if (rst) begin
                line_q.delete();
                exp_serial = 1'b0;
                exp_busy   = 1'b0;
            end else begin
                if (v && exp_ready) begin
                    case (c)
                        2'b01:   begin m = 1; s = 1; end
                        2'b10:   begin m = 3; s = 1; end
                        2'b11:   begin m = 0; s = 2; end
                        default: begin m = 0; s = 6; end
                    endcase
                    repeat (m * U) line_q.push_back(1'b1);
                    repeat (s * U) line_q.push_back(1'b0);
                end
                if (line_q.size() > 0) begin
                    exp_serial = line_q.pop_front();
                    exp_busy   = 1'b1;
                end else begin
                    exp_serial = 1'b0;
                    exp_busy   = 1'b0;
                end
            end
            exp_ready = (line_q.size() == 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("serial0", 32'(serial0), 32'(mdl[0].exp_serial));
            check("busy0",   32'(busy0),   32'(mdl[0].exp_busy));
            check("ready0",  32'(ready0),  32'(mdl[0].exp_ready));
            check("serial1", 32'(serial1), 32'(mdl[1].exp_serial));
            check("busy1",   32'(busy1),   32'(mdl[1].exp_busy));
            check("ready1",  32'(ready1),  32'(mdl[1].exp_ready));
        end
    end

    // Waveform history for pattern checks over whole symbol sequences.
    always @(negedge clk) begin
        if (cyc < 4096) begin
            hist_s0[cyc] = serial0;
            hist_s1[cyc] = serial1;
            hist_r1[cyc] = ready1;
        end
    end

    // Present one symbol; returns at the falling edge after the transfer.
    task automatic send(input int g, input logic [1:0] c, input bit hold);
        int n;
        if (g == 0) begin code0 = c; valid0 = 1'b1; end
        else        begin code1 = c; valid1 = 1'b1; end
        n = 0;
        while (!((g == 0) ? ready0 : ready1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("handshake_ready", 32'((g == 0) ? ready0 : ready1), 32'd1);
        @(negedge clk);
        if (!hold) begin
            if (g == 0) valid0 = 1'b0;
            else        valid1 = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        logic [31:0] v;

        rst    = 1'b1;
        code0  = 2'b00;
        code1  = 2'b00;
        valid0 = 1'b0;
        valid1 = 1'b0;

        // Reset for two cycles, then quiet for 20 cycles.
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_serial", 32'(serial0), 32'd0);
        check("rst_busy",   32'(busy0),   32'd0);
        check("rst_ready",  32'(ready0),  32'd1);
        idle(20);
        check("quiet_serial", 32'(serial0), 32'd0);
        check("quiet_ready",  32'(ready0),  32'd1);

        // Single dot: high at cycle 1, low at cycle 2, idle at cycle 3.
        send(0, 2'b01, 1'b0);
        check("dot_c1_serial", 32'(serial0), 32'd1);
        check("dot_c1_ready",  32'(ready0),  32'd0);
        check("dot_c1_busy",   32'(busy0),   32'd1);
        @(negedge clk);
        check("dot_c2_serial", 32'(serial0), 32'd0);
        check("dot_c2_ready",  32'(ready0),  32'd1);
        check("dot_c2_busy",   32'(busy0),   32'd1);
        @(negedge clk);
        check("dot_c3_busy",   32'(busy0),   32'd0);
        idle(3);

        // Back-to-back stream 01,10,11,00 with valid held high.
        t0 = cyc;
        send(0, 2'b01, 1'b1);
        send(0, 2'b10, 1'b1);
        send(0, 2'b11, 1'b1);
        send(0, 2'b00, 1'b0);
        idle(10);
        v = '0;
        for (int r = 1; r <= 15; r++) v = {v[30:0], hist_s0[t0 + r]};
        check("stream_pattern", v, 32'b101110000000000);

        // UNIT_CYCLES=4 dash: 12 cycles high, 4 low, ready from cycle 16.
        t0 = cyc;
        send(1, 2'b10, 1'b0);
        idle(20);
        v = '0;
        for (int r = 1; r <= 17; r++) v = {v[30:0], hist_s1[t0 + r]};
        check("u4_dash_serial", v, 32'b11111111111100000);
        v = '0;
        for (int r = 1; r <= 17; r++) v = {v[30:0], hist_r1[t0 + r]};
        check("u4_dash_ready", v, 32'b00000000000000011);

        // Code changes while busy: the dot stays one unit, the dash follows.
        send(0, 2'b01, 1'b1);
        code0 = 2'b10;
        @(negedge clk);
        check("chg_c2_serial", 32'(serial0), 32'd0);
        @(negedge clk);
        valid0 = 1'b0;
        check("chg_c3_serial", 32'(serial0), 32'd1);
        idle(2);
        check("chg_c5_serial", 32'(serial0), 32'd1);
        @(negedge clk);
        check("chg_c6_serial", 32'(serial0), 32'd0);
        idle(3);

        // Reset in the middle of a dash, then a clean dot.
        send(0, 2'b10, 1'b0);
        @(negedge clk);
        check("abort_c2_serial", 32'(serial0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_c3_serial", 32'(serial0), 32'd0);
        check("abort_c3_busy",   32'(busy0),   32'd0);
        check("abort_c3_ready",  32'(ready0),  32'd1);
        @(negedge clk);
        send(0, 2'b01, 1'b0);
        check("abort_c5_serial", 32'(serial0), 32'd1);
        @(negedge clk);
        check("abort_c6_serial", 32'(serial0), 32'd0);
        idle(4);
        check("abort_end_serial", 32'(serial0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
